// File: rtl/mv_mult_seq.sv
// ---------------------------------------------------------------------------
// mv_mult_seq
// Sequential matrix-vector multiplier controller. An N x N matrix and an
// N-element vector are loaded over a W-bit valid/ready byte stream. One
// multiply-accumulate unit then works through all N*N products, row by row.
// The N row sums are streamed out under valid/ready backpressure.
// The matrix is kept across jobs, so a job can reload only the vector.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   start       begin a job (sampled only in IDLE)
//   reload_mat  with start: 1 = load matrix then vector, 0 = vector only
//   in_valid    in_data is valid
//   in_data     matrix element (row-major) or vector element (index 0 first)
//   in_ready    block accepts in_data this cycle
//   out_valid   out_data holds a row result
//   out_data    row result, rows in order 0..N-1
//   out_ready   consumer accepts out_data
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the last result handshake
// ---------------------------------------------------------------------------
module mv_mult_seq #(
   parameter int N     = 2,
   parameter int W     = 4,
   parameter int ACC_W = 2*W + $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             reload_mat,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   localparam int            IW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, OUTPUT} state_t;

   state_t           state, state_next;
   logic [IW-1:0]    row, col, idx;
   logic [ACC_W-1:0] acc, acc_next;
   logic [2*W-1:0]   prod;
   logic             mat_loaded;
   logic             in_xfer, out_xfer;

   logic [W-1:0]     mat [N][N];
   logic [W-1:0]     vec [N];
   logic [ACC_W-1:0] res [N];

   assign in_ready  = (state == LOAD_M) || (state == LOAD_V);
   assign out_valid = (state == OUTPUT);
   assign busy      = (state != IDLE);
   assign out_data  = out_valid ? res[idx] : '0;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // Product width 2W; the zero-extension to ACC_W leaves room for N sums.
   assign prod     = mat[row][col] * vec[col];
   assign acc_next = ((col == '0) ? '0 : acc) + ACC_W'(prod);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples pre-edge values; blocking here would create order races.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assigned first so no path leaves state_next unassigned,
      // which would infer a latch.
      state_next = state;
      unique case (state)
         IDLE:    if (start)
                     state_next = (reload_mat || !mat_loaded) ? LOAD_M : LOAD_V;
         LOAD_M:  if (in_xfer && row == LAST && col == LAST) state_next = LOAD_V;
         LOAD_V:  if (in_xfer && col == LAST)                state_next = COMPUTE;
         COMPUTE: if (row == LAST && col == LAST)            state_next = OUTPUT;
         OUTPUT:  if (out_xfer && idx == LAST)               state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: register files, indices, accumulator, flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the register files are cleared on reset so a job can never
         // observe stale data; kept in flops, not a RAM macro, for this reason.
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) mat[i][j] <= '0;
            vec[i] <= '0;
            res[i] <= '0;
         end
         row        <= '0;
         col        <= '0;
         idx        <= '0;
         acc        <= '0;
         mat_loaded <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= out_xfer && (idx == LAST);
         unique case (state)
            IDLE: begin
               if (start) begin
                  row <= '0;
                  col <= '0;
               end
            end
            LOAD_M: begin
               if (in_xfer) begin
                  mat[row][col] <= in_data;
                  if (col == LAST) begin
                     col <= '0;
                     if (row == LAST) begin
                        row        <= '0;
                        mat_loaded <= 1'b1;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            LOAD_V: begin
               if (in_xfer) begin
                  vec[col] <= in_data;
                  if (col == LAST) begin
                     col <= '0;
                     row <= '0;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               acc <= acc_next;
               if (col == LAST) begin
                  res[row] <= acc_next;
                  col      <= '0;
                  if (row == LAST) begin
                     row <= '0;
                     idx <= '0;
                  end else begin
                     row <= row + 1'b1;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end
            OUTPUT: begin
               if (out_xfer) idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mv_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_mv_mult_seq
// Directed self-checking bench for mv_mult_seq with N=2, W=4 (ACC_W=9).
// Expected results are hand-computed constants in the stimulus below.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge or 1 unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mv_mult_seq;

   localparam int N     = 2;
   localparam int W     = 4;
   localparam int ACC_W = 2*W + $clog2(N);

   logic             clk = 1'b0;
   logic             rst;
   logic             start, reload_mat;
   logic             in_valid;
   logic [W-1:0]     in_data;
   logic             in_ready;
   logic             out_valid;
   logic [ACC_W-1:0] out_data;
   logic             out_ready;
   logic             busy, done;

   int n_vec = 0;
   int n_err = 0;

   mv_mult_seq #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .reload_mat (reload_mat),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic reload);
      start      = 1'b1;
      reload_mat = reload;
      tick();
      start      = 1'b0;
      reload_mat = 1'b0;
   endtask

   // Offer one element; returns after the accepting edge (+1).
   task automatic send(input string tag, input logic [W-1:0] d);
      bit ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (ok) tick();
      else    check({tag, "_in_ready_timeout"}, 0, 1);
      in_valid = 1'b0;
   endtask

   // Wait for a result, compare it, complete the handshake.
   task automatic recv(input string tag, input logic [ACC_W-1:0] exp);
      bit ok = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1;
            break;
         end
      end
      if (ok) begin
         check(tag, out_data, exp);
         tick();
      end else begin
         check({tag, "_out_valid_timeout"}, 0, 1);
      end
   endtask

   task automatic send_vec(input string tag, input logic [W-1:0] v0, input logic [W-1:0] v1);
      send({tag, "_v0"}, v0);
      send({tag, "_v1"}, v1);
   endtask

   task automatic send_mat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
      send({tag, "_m0"}, a);
      send({tag, "_m1"}, b);
      send({tag, "_m2"}, c);
      send({tag, "_m3"}, d);
   endtask

   // Last result handshake is done: done pulses now, then drops with busy low.
   task automatic check_done(input string tag);
      check({tag, "_done_pulse"}, done, 1);
      tick();
      check({tag, "_done_clear"}, done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; reload_mat = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_data", out_data, 0);
      tick();
      rst = 1'b0;
      tick();

      // 1: M=[1,2;3,4], v=[5,6] -> 17, 39; latency N*N=4 edges
      do_start(1'b1);
      check("s1_busy", busy, 1);
      send_mat("s1", 4'd1, 4'd2, 4'd3, 4'd4);
      send_vec("s1", 4'd5, 4'd6);
      check("s1_compute_in_ready", in_ready, 0);
      out_ready = 1'b1;
      tick(); tick(); tick();
      check("s1_lat3_out_valid", out_valid, 0);
      tick();
      check("s1_lat4_out_valid", out_valid, 1);
      recv("s1_row0", 9'd17);
      check("s1_mid_done", done, 0);
      recv("s1_row1", 9'd39);
      check_done("s1");

      // 3: reuse matrix, v=[1,1] -> 3, 7; exactly two input transfers
      do_start(1'b0);
      check("s3_in_ready_first", in_ready, 1);
      send_vec("s3", 4'd1, 4'd1);
      @(negedge clk);
      check("s3_in_ready_after2", in_ready, 0);
      tick();
      recv("s3_row0", 9'd3);
      recv("s3_row1", 9'd7);
      check_done("s3");

      // 4: backpressure on first result for 5 cycles
      out_ready = 1'b0;
      do_start(1'b1);
      send_mat("s4", 4'd1, 4'd2, 4'd3, 4'd4);
      send_vec("s4", 4'd5, 4'd6);
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("s4_hold_valid", out_valid, 1);
         check("s4_hold_data", out_data, 17);
         check("s4_hold_done", done, 0);
      end
      tick();
      recv("s4_row0", 9'd17);
      check("s4_mid_done", done, 0);
      recv("s4_row1", 9'd39);
      check_done("s4");

      // 2: all 15 -> 450, 450
      do_start(1'b1);
      send_mat("s2", 4'd15, 4'd15, 4'd15, 4'd15);
      send_vec("s2", 4'd15, 4'd15);
      recv("s2_row0", 9'd450);
      recv("s2_row1", 9'd450);
      check_done("s2");

      // 5: reset during COMPUTE, then reload_mat=0 must still load a matrix
      do_start(1'b0);
      send_vec("s5", 4'd2, 4'd2);
      tick();
      rst = 1'b1;
      #1;
      check("s5_rst_busy", busy, 0);
      check("s5_rst_out_valid", out_valid, 0);
      check("s5_rst_in_ready", in_ready, 0);
      check("s5_rst_out_data", out_data, 0);
      check("s5_rst_done", done, 0);
      tick();
      rst = 1'b0;
      tick();
      do_start(1'b0);
      send_mat("s5", 4'd2, 4'd0, 4'd0, 4'd3);
      send_vec("s5", 4'd4, 4'd5);
      recv("s5_row0", 9'd8);
      recv("s5_row1", 9'd15);
      check_done("s5");

      // 6: stray in_valid in IDLE/COMPUTE, start during OUTPUT
      in_valid = 1'b1; in_data = 4'd9; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("s6_idle_in_ready", in_ready, 0);
         check("s6_idle_busy", busy, 0);
      end
      tick();
      in_valid = 1'b0;
      do_start(1'b0);
      send_vec("s6", 4'd4, 4'd5);
      in_valid = 1'b1; in_data = 4'd9;
      for (int i = 0; i < 4; i++) tick();
      in_valid = 1'b0;
      check("s6_reached_output", out_valid, 1);
      start = 1'b1; reload_mat = 1'b1;
      tick();
      start = 1'b0; reload_mat = 1'b0;
      @(negedge clk);
      check("s6_start_ignored_valid", out_valid, 1);
      check("s6_start_ignored_data", out_data, 8);
      tick();
      recv("s6_row0", 9'd8);
      recv("s6_row1", 9'd15);
      check_done("s6");
      // Matrix untouched by stray 9s: v=[1,1] -> 2, 3
      do_start(1'b0);
      send_vec("s6b", 4'd1, 4'd1);
      recv("s6b_row0", 9'd2);
      recv("s6b_row1", 9'd3);
      check_done("s6b");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
